// File: rtl/aes_key_expand_param_if.sv
// Bundle of the key-expansion control, key and round-key signals shared between
// the cipher datapath (master) and the expansion engine (slave).
interface aes_key_expand_param_if #(
    parameter int WW     = 4,
    parameter int NW     = 4,
    parameter int ROUNDS = 10
);
    localparam int RW = $clog2(ROUNDS + 1);

    logic               kld;
    logic [WW*NW-1:0]   key;
    logic               adv;
    logic [WW*NW-1:0]   wo;
    logic               rk_valid;
    logic [RW-1:0]      round;
    logic               busy;
    logic               done;
    logic [RW-1:0]      rd_idx;
    logic [WW*NW-1:0]   rd_key;

    modport master (
        output kld, key, adv, rd_idx,
        input  wo, rk_valid, round, busy, done, rd_key
    );

    modport slave (
        input  kld, key, adv, rd_idx,
        output wo, rk_valid, round, busy, done, rd_key
    );
endinterface

// File: rtl/aes_key_expand_param.sv
// Round-counted rotate/rcon/prefix-XOR key expansion, one round per adv cycle.
// Define AES_KEXP_STORE_EN to keep every produced round key readable via rd_idx.
module aes_key_expand_param #(
    parameter int             WW        = 4,
    parameter int             NW        = 4,
    parameter int             ROUNDS    = 10,
    parameter logic [WW-1:0]  RCON_INIT = 1,
    parameter logic [WW-1:0]  POLY      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    aes_key_expand_param_if.slave   kx
);
    localparam int            RW   = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, EXPAND, FINISHED} state_t;

    state_t         state_reg, state_next;
    logic [WW-1:0]  w_reg    [NW];
    logic [WW-1:0]  w_next   [NW];
    logic [WW-1:0]  key_w    [NW];
    logic [WW-1:0]  step_w   [NW];
    logic [WW-1:0]  rcon_reg, rcon_next;
    logic [RW-1:0]  round_reg, round_next;
    logic           done_reg, done_next;
    logic [WW-1:0]  t_word;
    logic [WW-1:0]  rcon_step;
    logic           step_en;
    logic [WW*NW-1:0] wo_packed;
    logic [WW*NW-1:0] step_packed;

    assign t_word    = {w_reg[NW-1][WW-2:0], w_reg[NW-1][WW-1]} ^ rcon_reg;
    assign rcon_step = {rcon_reg[WW-2:0], 1'b0} ^ (rcon_reg[WW-1] ? POLY : '0);
    assign step_en   = (state_reg == EXPAND) && kx.adv && !kx.kld;

    // Word 0 sits in the most significant slice of the packed key.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_words
            assign key_w[gi] = kx.key[WW*(NW-gi)-1 -: WW];
            if (gi == 0) begin : g_first
                assign step_w[gi] = t_word ^ w_reg[0];
            end else begin : g_rest
                assign step_w[gi] = step_w[gi-1] ^ w_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        wo_packed   = '0;
        step_packed = '0;
        for (int i = 0; i < NW; i++) begin
            wo_packed[WW*(NW-i)-1 -: WW]   = w_reg[i];
            step_packed[WW*(NW-i)-1 -: WW] = step_w[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        round_next = round_reg;
        rcon_next  = rcon_reg;
        done_next  = 1'b0;
        if (kx.kld) begin
            state_next = EXPAND;
            w_next     = key_w;
            round_next = '0;
            rcon_next  = RCON_INIT;
        end else if (step_en) begin
            w_next     = step_w;
            round_next = round_reg + 1'b1;
            rcon_next  = rcon_step;
            if (round_reg == LAST) begin
                done_next  = 1'b1;
                state_next = FINISHED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            for (int i = 0; i < NW; i++) begin
                w_reg[i] <= '0;
            end
            rcon_reg  <= RCON_INIT;
            round_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            rcon_reg  <= rcon_next;
            round_reg <= round_next;
            done_reg  <= done_next;
        end
    end

    assign kx.wo       = wo_packed;
    assign kx.rk_valid = (state_reg != IDLE);
    assign kx.busy     = (state_reg == EXPAND);
    assign kx.round    = round_reg;
    assign kx.done     = done_reg;

`ifdef AES_KEXP_STORE_EN
    logic [WW*NW-1:0] store_reg [ROUNDS+1];

    // A reload wipes stale keys so rounds not yet reproduced read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= ROUNDS; j++) begin
                store_reg[j] <= '0;
            end
        end else if (kx.kld) begin
            for (int j = 1; j <= ROUNDS; j++) begin
                store_reg[j] <= '0;
            end
            store_reg[0] <= kx.key;
        end else if (step_en) begin
            store_reg[round_reg + 1'b1] <= step_packed;
        end
    end

    assign kx.rd_key = (kx.rd_idx > round_reg) ? '0 : store_reg[kx.rd_idx];
`else
    assign kx.rd_key = '0;
`endif
endmodule

// File: tb/tb_aes_key_expand_param.sv
// Self-checking bench for aes_key_expand_param against a word-level reference
// of the expansion schedule; honours AES_KEXP_STORE_EN when defined.
module tb_aes_key_expand_param;
    localparam int WW     = 4;
    localparam int NW     = 4;
    localparam int ROUNDS = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    aes_key_expand_param_if #(.WW(WW), .NW(NW), .ROUNDS(ROUNDS)) kx ();

    aes_key_expand_param #(.WW(WW), .NW(NW), .ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kx)
    );

    // Reference: expand k0 by n rounds using plain integer arithmetic.
    function automatic logic [15:0] model_key(input logic [15:0] k0, input int n);
        int w[4];
        int rc;
        int t;
        int acc;
        logic [15:0] r;
        for (int i = 0; i < 4; i++) w[i] = (int'(k0) >> (12 - 4*i)) & 15;
        rc = 1;
        for (int s = 0; s < n; s++) begin
            t   = (((w[3] << 1) | (w[3] >> 3)) & 15) ^ rc;
            acc = t;
            for (int i = 0; i < 4; i++) begin
                acc  = acc ^ w[i];
                w[i] = acc;
            end
            rc = rc * 2;
            if (rc > 15) rc = rc ^ 19;
        end
        r = 16'(w[0] * 4096 + w[1] * 256 + w[2] * 16 + w[3]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] k);
        kx.key = k;
        kx.kld = 1'b1;
        tick();
        kx.kld = 1'b0;
        $display("load key=%h -> wo=%h round=%0d busy=%0d", k, kx.wo, kx.round, kx.busy);
    endtask

    task automatic check_state(input string tag, input logic [15:0] k0, input int cur,
                               input logic exp_done, input logic exp_busy);
        check({tag, ".wo"},    32'(kx.wo),       32'(model_key(k0, cur)));
        check({tag, ".round"}, 32'(kx.round),    32'(cur));
        check({tag, ".done"},  32'(kx.done),     32'(exp_done));
        check({tag, ".busy"},  32'(kx.busy),     32'(exp_busy));
        check({tag, ".valid"}, 32'(kx.rk_valid), 32'd1);
    endtask

    // Uses one time unit of the current cycle to let the combinational read settle.
    task automatic check_store(input string tag, input logic [15:0] k0, input int cur, input int idx);
        logic [15:0] exp;
        kx.rd_idx = 4'(idx);
        #1;
`ifdef AES_KEXP_STORE_EN
        exp = (idx <= cur) ? model_key(k0, idx) : 16'h0000;
`else
        exp = 16'h0000;
`endif
        check(tag, 32'(kx.rd_key), 32'(exp));
    endtask

    initial begin
        logic [15:0] k;
        int cur;
        kx.kld = 1'b0; kx.adv = 1'b0; kx.key = '0; kx.rd_idx = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset.wo", 32'(kx.wo), 32'd0);
        check("reset.valid", 32'(kx.rk_valid), 32'd0);
        check("reset.round", 32'(kx.round), 32'd0);
        check("reset.busy", 32'(kx.busy), 32'd0);
        check("reset.done", 32'(kx.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // adv is ignored while idle
        kx.adv = 1'b1;
        repeat (3) tick();
        check("idle.wo", 32'(kx.wo), 32'd0);
        check("idle.valid", 32'(kx.rk_valid), 32'd0);
        check("idle.round", 32'(kx.round), 32'd0);
        kx.adv = 1'b0;

        // Directed known-answer sequence
        load(16'h1234);
        check_state("kat.r0", 16'h1234, 0, 1'b0, 1'b1);
        check("kat.r0.const", 32'(kx.wo), 32'h1234);
        kx.adv = 1'b1;
        tick();
        check("kat.r1.const", 32'(kx.wo), 32'h8A9D);
        check_state("kat.r1", 16'h1234, 1, 1'b0, 1'b1);
        tick();
        check("kat.r2.const", 32'(kx.wo), 32'h1B2F);
        check("kat.r2.round", 32'(kx.round), 32'd2);
        kx.adv = 1'b0;

        load(16'h0000);
        kx.adv = 1'b1;
        tick();
        check("zero.r1", 32'(kx.wo), 32'h1111);
        kx.adv = 1'b0;

        // Random keys, continuous adv through completion and beyond
        for (int trial = 0; trial < 4; trial++) begin
            k = 16'($urandom);
            load(k);
            check_store("run.store0", k, 0, 0);
            kx.adv = 1'b1;
            for (int r = 1; r <= ROUNDS; r++) begin
                tick();
                check_state("run", k, r, r == ROUNDS, r < ROUNDS);
                check_store("run.store", k, r, $urandom_range(0, ROUNDS));
            end
            $display("expand key=%h final=%h done=%0d", k, kx.wo, kx.done);
            repeat (2) begin
                tick();
                check_state("post", k, ROUNDS, 1'b0, 1'b0);
            end
            kx.adv = 1'b0;
        end

        // Stall for 5 cycles mid-run, then random adv pattern to completion
        k = 16'($urandom);
        load(k);
        cur = 0;
        kx.adv = 1'b1;
        repeat (3) begin
            tick();
            cur++;
        end
        kx.adv = 1'b0;
        repeat (5) begin
            tick();
            check_state("stall", k, cur, 1'b0, 1'b1);
        end
        for (int c = 0; c < 60 && cur < ROUNDS; c++) begin
            kx.adv = 1'($urandom_range(0, 1));
            tick();
            if (kx.adv) cur++;
            check_state("rand", k, cur, kx.adv && cur == ROUNDS, cur < ROUNDS);
        end
        check("rand.reached", 32'(cur), 32'(ROUNDS));
        kx.adv = 1'b0;
        $display("stall run key=%h final round=%0d", k, kx.round);

        // kld beats adv at round 4
        load(16'($urandom));
        kx.adv = 1'b1;
        repeat (4) tick();
        check("restart.pre.round", 32'(kx.round), 32'd4);
        kx.key = 16'h1234;
        kx.kld = 1'b1;
        tick();
        kx.kld = 1'b0;
        kx.adv = 1'b0;
        check_state("restart", 16'h1234, 0, 1'b0, 1'b1);
        check_store("restart.idx1", 16'h1234, 0, 1);
        tick();
        check_store("restart.idx1.held", 16'h1234, 0, 1);
        kx.adv = 1'b1;
        tick();
        kx.adv = 1'b0;
        check("restart.r1", 32'(kx.wo), 32'h8A9D);
        check_store("restart.idx1.adv", 16'h1234, 1, 1);
        $display("restart key=1234 wo=%h rd_key=%h", kx.wo, kx.rd_key);

        // Asynchronous reset between edges mid-expansion
        load(16'($urandom));
        kx.adv = 1'b1;
        repeat (3) tick();
        kx.adv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset.wo", 32'(kx.wo), 32'd0);
        check("areset.valid", 32'(kx.rk_valid), 32'd0);
        check("areset.busy", 32'(kx.busy), 32'd0);
        check("areset.round", 32'(kx.round), 32'd0);
        $display("async reset applied mid-expansion");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("areset.after.valid", 32'(kx.rk_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
